// File: rtl/multicycle_control.sv
// Moore multicycle controller for the shared-ALU / unified-memory MIPS datapath.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       trap,
  output logic [1:0] trap_code,
  output logic [3:0] state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    TRAP   = 4'd12,
    ILL13  = 4'd13,
    ILL14  = 4'd14,
    ILL15  = 4'd15
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  stateT curState, nextState;
  logic [1:0] trapCause;
  logic [TO_W-1:0] toCnt;
  logic timedOut;

  // zero only qualifies PCWriteCond inside the datapath's PC enable
  logic unusedZero;
  assign unusedZero = zero;

  assign state    = curState;
  assign timedOut = (toCnt == TO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) curState <= FETCH;
    else     curState <= nextState;
  end

  always_comb begin
    nextState = curState;
    trapCause = 2'b00;
    unique case (curState)
      FETCH: begin
        if (mem_ready) nextState = DECODE;
        else if (timedOut) begin
          nextState = TRAP;
          trapCause = TRAP_TIMEOUT;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             nextState = MEMADR;
          OP_RTYPE:                 nextState = EXEC;
          OP_BEQ:                   nextState = BRANCH;
          OP_J:                     nextState = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: nextState = IEXEC;
          default: begin
            nextState = TRAP;
            trapCause = TRAP_ILLEGAL;
          end
        endcase
      end
      MEMADR: nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (mem_ready) nextState = MEMWB;
        else if (timedOut) begin
          nextState = TRAP;
          trapCause = TRAP_TIMEOUT;
        end
      end
      MEMWB: nextState = FETCH;
      MEMWR: begin
        if (mem_ready) nextState = FETCH;
        else if (timedOut) begin
          nextState = TRAP;
          trapCause = TRAP_TIMEOUT;
        end
      end
      EXEC:   nextState = RWB;
      RWB:    nextState = FETCH;
      BRANCH: nextState = FETCH;
      JUMP:   nextState = FETCH;
      IEXEC:  nextState = IWB;
      IWB:    nextState = FETCH;
      TRAP:   nextState = TRAP;
      default: begin
        nextState = TRAP;
        trapCause = TRAP_ILLEGAL;
      end
    endcase
  end

  // Any state change clears the counter, so it restarts on every memory-state entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) toCnt <= '0;
    else if (nextState != curState) toCnt <= '0;
    else if (curState inside {FETCH, MEMRD, MEMWR}) toCnt <= toCnt + TO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap      <= 1'b0;
      trap_code <= 2'b00;
    end else if (curState != TRAP && nextState == TRAP) begin
      trap      <= 1'b1;
      trap_code <= trapCause;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    unique case (curState)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
      end
      IWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (curState != TRAP) cycle_count <= cycle_count + 32'd1;
      if (nextState == FETCH && curState != FETCH) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle queues its expected
// state/control word; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk, rst, zero, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, trap;
  logic [1:0] ALUSrcB, ALUOp, PCSource, trap_code;
  logic [3:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  multicycle_control #(.MEM_TIMEOUT(15), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .trap(trap), .trap_code(trap_code), .state(state)
`ifdef PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4,
                         S_MW = 4'd5, S_EX = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_J = 4'd9,
                         S_IE = 4'd10, S_IWB = 4'd11, S_TRAP = 4'd12;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_BAD = 6'b111111;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        tr;
    logic [1:0]  tc;
  } expT;

  expT q[$];
  expT mon;
  int  nCompared = 0;
  int  nMismatched = 0;

  logic [15:0] ctrlNow;
  assign ctrlNow = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource
  function automatic logic [15:0] ctrlFor(input logic [3:0] s, input logic mr, input logic [5:0] op);
    logic [15:0] c;
    c = '0;
    case (s)
      S_F:   begin c[12] = 1'b1; c[5:4] = 2'b01; c[15] = mr; c[10] = mr; end
      S_D:   c[5:4] = 2'b11;
      S_MA:  begin c[6] = 1'b1; c[5:4] = 2'b10; end
      S_MR:  begin c[12] = 1'b1; c[13] = 1'b1; end
      S_MWB: begin c[9] = 1'b1; c[7] = 1'b1; end
      S_MW:  begin c[11] = 1'b1; c[13] = 1'b1; end
      S_EX:  begin c[6] = 1'b1; c[3:2] = 2'b10; end
      S_RWB: begin c[8] = 1'b1; c[7] = 1'b1; end
      S_BR:  begin c[6] = 1'b1; c[3:2] = 2'b01; c[14] = 1'b1; c[1:0] = 2'b01; end
      S_J:   begin c[15] = 1'b1; c[1:0] = 2'b10; end
      S_IE:  begin c[6] = 1'b1; c[5:4] = 2'b10; c[3:2] = (op == OP_ADDI) ? 2'b00 : 2'b11; end
      S_IWB: c[7] = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon = q.pop_front();
      chk("state", {28'd0, state}, {28'd0, mon.st});
      chk("ctrl", {16'd0, ctrlNow}, {16'd0, mon.ctrl});
      chk("trap", {31'd0, trap}, {31'd0, mon.tr});
      chk("trap_code", {30'd0, trap_code}, {30'd0, mon.tc});
    end
  end

  // Drive one cycle of inputs and queue what the DUT must show during that cycle
  task automatic cyc(input logic r, input logic mr, input logic [5:0] op, input logic z,
                     input logic [3:0] es, input logic et, input logic [1:0] ec);
    rst = r; mem_ready = mr; opcode = op; zero = z;
    q.push_back('{st: es, ctrl: ctrlFor(es, mr, op), tr: et, tc: ec});
    @(posedge clk); #1;
  endtask

  task automatic runR(input logic [5:0] op);
    cyc(0, 1, op, 0, S_F, 0, 2'b00);
    cyc(0, 1, op, 0, S_D, 0, 2'b00);
    cyc(0, 1, op, 0, S_EX, 0, 2'b00);
    cyc(0, 1, op, 0, S_RWB, 0, 2'b00);
  endtask

  task automatic runShort(input logic [5:0] op, input logic z, input logic [3:0] third);
    cyc(0, 1, op, z, S_F, 0, 2'b00);
    cyc(0, 1, op, z, S_D, 0, 2'b00);
    cyc(0, 1, op, z, third, 0, 2'b00);
  endtask

  task automatic runImm(input logic [5:0] op);
    cyc(0, 1, op, 0, S_F, 0, 2'b00);
    cyc(0, 1, op, 0, S_D, 0, 2'b00);
    cyc(0, 1, op, 0, S_IE, 0, 2'b00);
    cyc(0, 1, op, 0, S_IWB, 0, 2'b00);
  endtask

  task automatic runLw(input int unsigned waits);
    cyc(0, 1, OP_LW, 0, S_F, 0, 2'b00);
    cyc(0, 1, OP_LW, 0, S_D, 0, 2'b00);
    cyc(0, 1, OP_LW, 0, S_MA, 0, 2'b00);
    for (int unsigned i = 0; i < waits; i++) cyc(0, 0, OP_LW, 0, S_MR, 0, 2'b00);
    cyc(0, 1, OP_LW, 0, S_MR, 0, 2'b00);
    cyc(0, 1, OP_LW, 0, S_MWB, 0, 2'b00);
  endtask

  task automatic runSw();
    cyc(0, 1, OP_SW, 0, S_F, 0, 2'b00);
    cyc(0, 1, OP_SW, 0, S_D, 0, 2'b00);
    cyc(0, 1, OP_SW, 0, S_MA, 0, 2'b00);
    cyc(0, 1, OP_SW, 0, S_MW, 0, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = OP_R; zero = 1'b0;
    @(posedge clk); #1;
    cyc(1, 1, OP_R, 0, S_F, 0, 2'b00);

    runR(OP_R);
    runLw(3);
    runSw();
    runShort(OP_BEQ, 1, S_BR);
    runShort(OP_BEQ, 0, S_BR);
    runShort(OP_J, 0, S_J);
    runImm(OP_ADDI);
    runImm(OP_ANDI);
    runImm(OP_ORI);

    // 15 counted waits, then mem_ready arrives on the limit cycle
    for (int unsigned i = 0; i < 15; i++) cyc(0, 0, OP_R, 0, S_F, 0, 2'b00);
    cyc(0, 1, OP_R, 0, S_F, 0, 2'b00);
    cyc(0, 1, OP_R, 0, S_D, 0, 2'b00);
    cyc(0, 1, OP_R, 0, S_EX, 0, 2'b00);
    cyc(0, 1, OP_R, 0, S_RWB, 0, 2'b00);

    // mid-instruction reset from EXEC
    cyc(0, 1, OP_R, 0, S_F, 0, 2'b00);
    cyc(0, 1, OP_R, 0, S_D, 0, 2'b00);
    cyc(1, 1, OP_R, 0, S_F, 0, 2'b00);

    // illegal opcode
    cyc(0, 1, OP_BAD, 0, S_F, 0, 2'b00);
    cyc(0, 1, OP_BAD, 0, S_D, 0, 2'b00);
    for (int unsigned i = 0; i < 3; i++) cyc(0, 1, OP_BAD, 0, S_TRAP, 1, 2'b01);
    cyc(1, 1, OP_R, 0, S_F, 0, 2'b00);

    // fetch timeout
    for (int unsigned i = 0; i < 16; i++) cyc(0, 0, OP_R, 0, S_F, 0, 2'b00);
    cyc(0, 1, OP_R, 0, S_TRAP, 1, 2'b10);
    cyc(0, 1, OP_R, 0, S_TRAP, 1, 2'b10);
    cyc(1, 1, OP_R, 0, S_F, 0, 2'b00);

`ifdef PERF_CNT_EN
    chk("cycle_count_reset", cycle_count, 32'd0);
    chk("instr_count_reset", instr_count, 32'd0);
    runR(OP_R);
    runLw(0);
    runSw();
    runShort(OP_BEQ, 1, S_BR);
    runShort(OP_J, 0, S_J);
    chk("cycle_count", cycle_count, 32'd19);
    chk("instr_count", instr_count, 32'd5);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style multicycle controller that sequences the shared MIPS datapath (single ALU, single unified memory port) through fetch, decode, execute, memory and writeback steps. It supports R-type, lw, sw, beq, j, addi, andi and ori. It replaces per-instruction combinational control with a state register. It waits on a memory ready handshake and traps on illegal opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before trapping (1..255)
TO_W, 8, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag, used in BRANCH
mem_ready  in  1  memory completed access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if zero
IorD  out  1  0=PC addresses memory, 1=ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  latch instruction register
MemtoReg  out  1  register writeback from MDR
RegDst  out  1  1=rd, 0=rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct, 11 logic-imm (ALU control decodes opcode)
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
trap  out  1  sticky error flag
trap_code  out  2  01 illegal opcode, 10 memory timeout
state  out  4  current state, for debug

Behaviour:
- Reset (async, rst=1): state=FETCH, trap=0, trap_code=00, timeout counter=0. Outputs take the FETCH decode.
- Outputs are decoded from the state register only. Exception: PCWrite/IRWrite in FETCH are gated by mem_ready.
- Any output not listed for a state is 0. ALUSrcB, ALUOp and PCSource default to 00.
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. mem_ready=1 -> DECODE, else stay.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - lw/sw (100011/101011) -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000/001100/001101 -> IEXEC
  - any other -> TRAP with trap_code=01
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD(3): MemRead=1, IorD=1. mem_ready -> MEMWB.
- MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. -> FETCH.
- MEMWR(5): MemWrite=1, IorD=1. mem_ready -> FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RWB.
- RWB(7): RegDst=1, RegWrite=1. -> FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
- JUMP(9): PCWrite=1, PCSource=10. -> FETCH.
- IEXEC(10): ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi/ori. -> IWB.
- IWB(11): RegDst=0, MemtoReg=0, RegWrite=1. -> FETCH.
- TRAP(12): all strobes 0. Stays until reset. States 13-15 -> TRAP with trap_code=01.
- Memory timeout:
  - Counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle spent waiting there with mem_ready=0.
  - On reaching MEM_TIMEOUT with mem_ready still 0 -> TRAP, trap_code=10.
  - mem_ready on the same cycle the counter hits the limit wins: normal transition, no trap.
- Instruction latencies: R/addi/andi/ori 4 cycles, lw 5, sw 4, beq 3, j 3, each plus memory wait cycles.
- Reset mid-instruction aborts immediately. No partial register write occurs after rst asserts.

Optional Feature:
PERF_CNT_EN: when defined, adds outputs cycle_count[31:0] and instr_count[31:0].
- cycle_count increments every cycle outside TRAP.
- instr_count increments on each transition into FETCH from a completing state.
- Both counters reset to 0 and wrap modulo 2^32.
When not defined, neither port exists and no counter logic is synthesised.

Test Plan:
- Reset, then opcode=000000 with mem_ready=1 always -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in cycle 4.
- lw (100011) with mem_ready low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. MemtoReg=1 in MEMWB.
- beq with zero=1, then with zero=0 -> PCWriteCond=1, PCSource=01 in BRANCH both times. 3-cycle sequence, returns to FETCH.
- opcode=111111 -> TRAP after DECODE, trap=1, trap_code=01. Stays in TRAP until rst, then FETCH with trap=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, trap_code=10. Second run with mem_ready=1 at the limit cycle -> DECODE, no trap.
- PERF_CNT_EN defined, run R,lw,sw,beq,j back-to-back with mem_ready=1 -> instr_count=5, cycle_count=19.
